tdc_hw_accum: RTL

Multi-sample Hamming-weight accumulator for the TDC capture path. It sits after the capture/sync stages in the capture clock domain. It takes one N-bit thermometer code per accepted sample and pop-counts it through a registered stage. Over a run-time-selected power-of-two number of samples it accumulates the sum, mean, minimum and maximum, and presents them on a valid/ready result port. It generalises the single-shot pop-count output with averaging, statistics and a handshaked run control.

---
 rtl/tdc_hw_accum.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tdc_hw_accum.sv
// tdc_hw_accum: multi-sample Hamming-weight accumulator for the TDC capture path.
// One thermometer word per accepted sample is pop-counted into a registered
// stage and then folded into sum / min / max over 2^k samples. The result is
// presented on a valid/ready port.
// Optional feature macro: TDC_HW_MINMAX_EN (min/max tracking; tied to 0 when undefined).
module tdc_hw_accum #(
    parameter  int N                = 64,
    parameter  int LOG2_MAX_SAMPLES = 8,
    localparam int W                = $clog2(N) + 1,
    localparam int A                = W + LOG2_MAX_SAMPLES,
    localparam int KW               = $clog2(LOG2_MAX_SAMPLES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          start,
    input  logic          abort,
    input  logic [KW-1:0] log2_samples,
    input  logic [N-1:0]  therm_in,
    input  logic          sample_valid,
    output logic          busy,
    output logic          result_valid,
    input  logic          result_ready,
    output logic [A-1:0]  hw_sum,
    output logic [W-1:0]  hw_mean,
    output logic [W-1:0]  hw_min,
    output logic [W-1:0]  hw_max
);

    // Sample counter must reach 2^LOG2_MAX_SAMPLES, hence one extra bit.
    localparam int            CW   = LOG2_MAX_SAMPLES + 1;
    localparam logic [KW-1:0] KMAX = KW'(LOG2_MAX_SAMPLES);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   hw_q;
    logic           hwv_q;
    logic [A-1:0]   sum_q;

    logic [CW-1:0]  target;
    logic [CW-1:0]  cnt_inc;
    logic           run_st;
    logic           accept;
    logic           fold;
    logic           launch;
    logic [KW-1:0]  k_clamped;

    // Ones count regardless of position: bubbles are counted, not corrected.
    function automatic logic [W-1:0] popcnt(input logic [N-1:0] v);
        logic [W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + W'(v[i]);
        return c;
    endfunction

    assign target    = CW'(1) << k_q;
    assign cnt_inc   = cnt_q + CW'(1);
    assign k_clamped = (log2_samples > KMAX) ? KMAX : log2_samples;
    assign run_st    = (state_q == ACCUM) || (state_q == DRAIN);
    assign launch    = (state_q == IDLE) && start && !abort;
    // en low freezes the whole run (pipeline register, counters, state).
    assign accept    = (state_q == ACCUM) && en && sample_valid && (cnt_q < target) && !abort;
    assign fold      = run_st && en && hwv_q && !abort;

    // Next-state logic; abort overrides everything and lands in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = ACCUM;
            ACCUM: if (accept && (cnt_inc == target)) state_d = DRAIN;
            // Leave DRAIN only once the last hw_q has been folded into the sum.
            DRAIN: if (en && !hwv_q) state_d = DONE;
            DONE:  if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Run setup, pop-count stage, sample counter and sum accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q   <= '0;
            cnt_q <= '0;
            hw_q  <= '0;
            hwv_q <= 1'b0;
            sum_q <= '0;
        end else if (abort) begin
            hwv_q <= 1'b0;
        end else if (launch) begin
            k_q   <= k_clamped;
            cnt_q <= '0;
            hwv_q <= 1'b0;
            sum_q <= '0;
        end else if (run_st && en) begin
            hwv_q <= accept;
            if (accept) begin
                hw_q  <= popcnt(therm_in);
                cnt_q <= cnt_inc;
            end
            if (fold) sum_q <= sum_q + A'(hw_q);
        end
    end

`ifdef TDC_HW_MINMAX_EN
    logic [W-1:0] min_q, max_q;

    // Running min/max, seeded to (N, 0) at run start so the first sample wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '0;
            max_q <= '0;
        end else if (launch) begin
            min_q <= W'(N);
            max_q <= '0;
        end else if (fold) begin
            if (hw_q < min_q) min_q <= hw_q;
            if (hw_q > max_q) max_q <= hw_q;
        end
    end

    assign hw_min = min_q;
    assign hw_max = max_q;
`else
    assign hw_min = '0;
    assign hw_max = '0;
`endif

    // k is held until the next start, so the mean stays stable with the sum.
    assign hw_sum       = sum_q;
    assign hw_mean      = W'(sum_q >> k_q);
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);

endmodule
